// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register RAW/WAW hazard scoreboard with ID stall, flush pass-through and stall counter
module hazard_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 4,
    parameter int PERF_W  = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_rd_wen,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                id_var,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                br_ctrl,
    output logic                stall,
    output logic                flush,
    output logic [REG_NUM-1:0]  busy_vec,
    output logic [PERF_W-1:0]   stall_cnt
);

    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] r_var;
    logic [CNT_W-1:0]   r_cnt [REG_NUM];
    logic [PERF_W-1:0]  r_stall_cnt;

    logic [REG_NUM-1:0] w_hit;
    logic               w_raw;
    logic               w_waw;
    logic               w_issue;
    logic               w_set;

    // A variable-latency result completing this cycle is bypassed, so it no longer blocks.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            w_hit[i] = r_busy[i] & ~(wb_valid & r_var[i] & (wb_rd == REG_AW'(i)));
        end
    end

    assign w_raw   = (id_rs1_used & w_hit[id_rs1]) | (id_rs2_used & w_hit[id_rs2]);
    assign w_waw   = id_rd_wen & (id_rd != '0) & w_hit[id_rd];
    assign stall   = id_valid & ~br_ctrl & (w_raw | w_waw);
    assign flush   = br_ctrl;
    assign w_issue = id_valid & ~stall & ~br_ctrl;
    assign w_set   = w_issue & id_rd_wen & (id_rd != '0) & (id_var | (id_lat != '0));

    // A new issue to a register overrides any completion landing on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
            r_var  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_set && (id_rd == REG_AW'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_var[i]  <= id_var;
                    r_cnt[i]  <= id_var ? '0 : id_lat;
                end else if (r_busy[i] && !r_var[i]) begin
                    if (r_cnt[i] > CNT_W'(1)) begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    end else begin
                        r_busy[i] <= 1'b0;
                        r_cnt[i]  <= '0;
                    end
                end else if (r_busy[i] && wb_valid && (wb_rd == REG_AW'(i))) begin
                    r_busy[i] <= 1'b0;
                    r_var[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign busy_vec  = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven bench for hazard_scoreboard plus async reset sequence
module tb_hazard_scoreboard;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  lat;
        logic        isv;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        br;
        logic        e_stall;
        logic        e_flush;
        logic [31:0] e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_var, wb_valid, br_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [3:0]  id_lat;
    logic        stall, flush, stall2, flush2;
    logic [31:0] busy_vec, busy_vec2;
    logic [31:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int n_checks = 0;
    int n_err    = 0;
    int row      = -1;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_NUM(32), .REG_AW(5), .CNT_W(4), .PERF_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_lat(id_lat), .id_var(id_var), .wb_valid(wb_valid), .wb_rd(wb_rd), .br_ctrl(br_ctrl),
        .stall(stall), .flush(flush), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.REG_NUM(32), .REG_AW(5), .CNT_W(4), .PERF_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_lat(id_lat), .id_var(id_var), .wb_valid(wb_valid), .wb_rd(wb_rd), .br_ctrl(br_ctrl),
        .stall(stall2), .flush(flush2), .busy_vec(busy_vec2), .stall_cnt(stall_cnt2)
    );

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic wen, input logic [3:0] lat, input logic isv,
                                input logic wbv, input logic [4:0] wbrd, input logic br,
                                input logic es, input logic ef, input logic [31:0] eb,
                                input logic [31:0] ec);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wen = wen;
        t.lat = lat; t.isv = isv; t.wbv = wbv; t.wbrd = wbrd; t.br = br;
        t.e_stall = es; t.e_flush = ef; t.e_busy = eb; t.e_cnt = ec;
        return t;
    endfunction

    function automatic vec_t bub(input logic [31:0] eb, input logic [31:0] ec);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb, ec);
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs1 = t.rs1; id_rs1_used = t.u1; id_rs2 = t.rs2; id_rs2_used = t.u2;
        id_rd = t.rd; id_rd_wen = t.wen; id_lat = t.lat; id_var = t.isv;
        wb_valid = t.wbv; wb_rd = t.wbrd; br_ctrl = t.br;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input logic es, input logic ef, input logic [31:0] eb, input logic [31:0] ec);
        chk("stall", {31'd0, stall}, {31'd0, es});
        chk("flush", {31'd0, flush}, {31'd0, ef});
        chk("busy_vec", busy_vec, eb);
        chk("stall_cnt", stall_cnt, ec);
        chk("stall_cnt_sat", {30'd0, stall_cnt2}, (ec > 32'd3) ? 32'd3 : ec);
    endtask

    initial begin
        vec_t t;
        rstn = 1'b0;
        t = mk(1, 5, 1, 5, 1, 5, 1, 3, 0, 0, 0, 1, 0, 1, 0, 0);
        drive(t);
        repeat (2) @(negedge clk);
        #1;
        chk_all(1'b0, 1'b1, 32'h0, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // load-use, lat=1
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0));
        tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        tbl.push_back(bub(32'h0, 1));
        // WAW against lat=6 on x10
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 6, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 32'h400, 32'(1 + k)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 7));
        tbl.push_back(bub(32'h0, 7));
        // variable latency x7, completion bypass
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 7));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'(7 + k)));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 7, 0, 0, 0, 32'h80, 15));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0, 15));
        // wb to a fixed-latency entry is ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 15));
        tbl.push_back(mk(1, 0, 0, 12, 1, 13, 1, 0, 0, 1, 12, 0, 1, 0, 32'h1000, 15));
        tbl.push_back(mk(1, 0, 0, 12, 1, 13, 1, 0, 0, 0, 0, 0, 1, 0, 32'h1000, 16));
        tbl.push_back(mk(1, 0, 0, 12, 1, 13, 1, 0, 0, 0, 0, 0, 1, 0, 32'h1000, 17));
        tbl.push_back(mk(1, 0, 0, 12, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 18));
        // flush priority over a RAW hazard
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 18));
        tbl.push_back(mk(1, 4, 1, 0, 0, 9, 1, 5, 0, 0, 0, 1, 0, 1, 32'h10, 18));
        tbl.push_back(bub(32'h10, 18));
        tbl.push_back(bub(32'h0, 18));
        // x0 never tracked
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 18));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 18));
        // set wins over same-edge completion on x3
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 18));
        tbl.push_back(bub(32'h8, 18));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 3, 0, 0, 0, 32'h8, 18));
        tbl.push_back(bub(32'h8, 18));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 32'h8, 18));
        tbl.push_back(bub(32'h0, 18));

        for (int r = 0; r < tbl.size(); r++) begin
            row = r;
            @(negedge clk);
            drive(tbl[r]);
            #1;
            chk_all(tbl[r].e_stall, tbl[r].e_flush, tbl[r].e_busy, tbl[r].e_cnt);
        end

        // asynchronous reset with three pending entries
        row = 1000;
        @(negedge clk); drive(mk(1, 0, 0, 0, 0, 20, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); drive(mk(1, 0, 0, 0, 0, 21, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); drive(mk(1, 0, 0, 0, 0, 22, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); drive(mk(1, 20, 1, 0, 0, 23, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        row = 1001;
        chk_all(1'b1, 1'b0, 32'h0070_0000, 32'd18);
        #1 rstn = 1'b0;
        #1;
        row = 1002;
        chk_all(1'b0, 1'b0, 32'h0, 32'd0);
        #1 rstn = 1'b1;
        @(negedge clk); drive(mk(1, 0, 0, 22, 1, 24, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        row = 1003;
        chk_all(1'b0, 1'b0, 32'h0, 32'd0);
        @(negedge clk); drive(bub(0, 0));
        #1;
        row = 1004;
        chk_all(1'b0, 1'b0, 32'h0100_0000, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the single-cycle load-use hazard detector in the AdamRiscv pipeline. It sits beside the ID stage and tracks every in-flight register write in a per-register scoreboard, covering fixed-latency units (load, multiply, matrix ops) and variable-latency units (matrix/memory completion reported at write-back). It generates the ID stall for RAW and WAW hazards, passes branch flush through, and counts stall cycles for performance monitoring.

## Interface
- REG_NUM, 32, number of architectural registers tracked
- REG_AW, 5, register address width; REG_NUM must equal 2**REG_AW
- CNT_W, 4, latency counter width; maximum fixed latency is 2**CNT_W-1
- PERF_W, 32, stall performance counter width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1, id_rs2  in  REG_AW  source register addresses
- id_rs1_used, id_rs2_used  in  1  source is actually read by the instruction
- id_rd  in  REG_AW  destination register
- id_rd_wen  in  1  instruction writes id_rd
- id_lat  in  CNT_W  fixed result latency in cycles; 0 means result is forwardable next cycle and is not tracked
- id_var  in  1  variable-latency result; overrides id_lat; completes via wb_valid
- wb_valid  in  1  variable-latency completion this cycle
- wb_rd  in  REG_AW  register completed by wb_valid
- br_ctrl  in  1  branch resolved taken / redirect
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- flush  out  1  kill the IF/ID instruction
- busy_vec  out  REG_NUM  registered scoreboard busy bits, bit i for register i
- stall_cnt  out  PERF_W  saturating count of cycles with stall=1

## Operation
- Per register i: busy[i] (1 bit), cnt[i] (CNT_W), var[i] (1 bit). Register 0 is never set busy; writes to x0 are ignored.
- hit(r) = busy[r] & ~(wb_valid & var[r] & wb_rd==r). A same-cycle completion is treated as bypassed.
- raw = (id_rs1_used & hit(id_rs1)) | (id_rs2_used & hit(id_rs2)).
- waw = id_rd_wen & id_rd!=0 & hit(id_rd).
- stall = id_valid & ~br_ctrl & (raw | waw). Flush has priority; a killed instruction never stalls.
- flush = br_ctrl. This output is combinational.
- issue = id_valid & ~stall & ~br_ctrl.
- On issue with id_rd_wen, id_rd!=0:
  - If id_var: set busy=1, var=1.
  - Else if id_lat>0: set busy=1, var=0, cnt=id_lat.
  - Else: no change.
- Fixed-latency entries (busy & ~var):
  - When cnt>1, cnt decrements by 1 each cycle.
  - When cnt==1, busy clears next edge and cnt becomes 0.
- Variable-latency entries clear busy and var on the edge where wb_valid & wb_rd==i.
- Simultaneous set and clear of the same register (issue writes rd while wb completes it): set wins.
- wb_valid targeting a register that is not busy, or one with var=0, is ignored.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.

## Timing
- Reset (rstn=0, asynchronous): all busy, var and cnt become 0; busy_vec=0; stall_cnt=0; stall=0 and flush=br_ctrl.
- Reset asserted mid-operation discards all pending entries. The first cycle after release shows no hazards.
- stall and flush are combinational from inputs and current state in the same cycle. There are no combinational paths from stall back into scoreboard inputs except through issue.
- Fixed latency L issued at cycle t:
  - busy_vec bit is 1 during cycles t+1 through t+L.
  - A dependent instruction in ID stalls during cycles t+1 through t+L and issues at t+L+1.
- Variable completion at cycle w: a dependent instruction in ID is not stalled at w (bypass) and issues at w.
- Back-to-back issues to different registers update independently in the same cycle.

## Test plan
- Load-use: issue lw x5, lat=1 at t0; add x6,x5,x1 in ID at t1 -> stall=1 at t1 only, issue at t2, stall_cnt=1.
- Long fixed latency with WAW: matrix op to x10, lat=6 at t0; next instr writes x10 with no sources read -> stall for t1..t6, issue t7; busy_vec[10]=1 over t1..t6.
- Variable latency with bypass: id_var issue to x7 at t0; consumer of x7 waits; wb_valid with wb_rd=7 at t9 -> stall=0 at t9 and consumer issues at t9; busy_vec[7]=0 at t10.
- Flush priority: raw hazard present and br_ctrl=1 in the same cycle -> stall=0, flush=1, no scoreboard set for the killed instruction, stall_cnt unchanged.
- x0 and set-wins: an instruction writing x0 with lat=5 -> busy_vec stays 0. wb of x3 in the same cycle an instruction issues to x3 with id_var=1 -> busy_vec[3]=1 next cycle.
- Asynchronous reset mid-flight: three pending entries (lat=7, var, lat=3), then pulse rstn low between edges -> busy_vec=0 and stall_cnt=0 immediately; a dependent instruction issues on the first cycle after release.
